// File: rtl/simd_mem_arbiter.sv
// Shares one non-pipelined data-memory port between the pipeline MEM stage (P) and an external loader (L).
// Optional grant/stall statistics counters are enabled by defining SIMD_MEM_ARB_STATS_EN.
module simd_mem_arbiter #(
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned MAX_CONSEC = 4,
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          p_rd,
  input  logic          p_wr,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          p_rvalid,
  output logic          p_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic [DW-1:0] l_rdata,
  output logic          l_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef SIMD_MEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_p_grants,
  output logic [15:0]   stat_l_grants,
  output logic [15:0]   stat_stall_cycles
`endif
);

  localparam int unsigned BW = 2;
  localparam int unsigned CW = 4;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_RD_WAIT = 1'b1;

  localparam logic OWN_P = 1'b0;
  localparam logic OWN_L = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [BW-1:0] busy_q, busy_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] consec_q, consec_d;
  logic          rst_q;
  logic [DW-1:0] p_rdata_q, p_rdata_d;
  logic [DW-1:0] l_rdata_q, l_rdata_d;

  logic rst_win;
  logic p_req;
  logic ret;
  logic ret_p;
  logic ret_l;
  logic can_issue;
  logic l_block_p;
  logic p_sel;
  logic issue_p;
  logic issue_l;
  logic p_read_issue;
  logic l_read_issue;

  // Arbitration and issue decision; outputs stay quiet during reset and the cycle after it.
  always_comb begin
    rst_win      = reset | rst_q;
    p_req        = p_rd | p_wr;
    ret          = !rst_win && (state_q == S_RD_WAIT) && (busy_q == '0);
    ret_p        = ret && (owner_q == OWN_P);
    ret_l        = ret && (owner_q == OWN_L);
    can_issue    = !rst_win && ((state_q == S_IDLE) || ret);
    l_block_p    = l_req && (consec_q == CW'(MAX_CONSEC));
    p_sel        = p_req && !l_block_p;
    issue_p      = can_issue && p_sel;
    issue_l      = can_issue && !p_sel && l_req;
    p_read_issue = issue_p && !p_wr;
    l_read_issue = issue_l && !l_we;
  end

  // Next-state logic: read sequencing, owner tracking and bounded P priority.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    owner_d   = owner_q;
    consec_d  = consec_q;
    p_rdata_d = p_rdata_q;
    l_rdata_d = l_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (p_read_issue || l_read_issue) begin
          state_d = S_RD_WAIT;
          busy_d  = BW'(READ_LAT - 1);
          owner_d = l_read_issue ? OWN_L : OWN_P;
        end
      end
      S_RD_WAIT: begin
        if (busy_q != '0) begin
          busy_d = busy_q - BW'(1);
        end else if (p_read_issue || l_read_issue) begin
          busy_d  = BW'(READ_LAT - 1);
          owner_d = l_read_issue ? OWN_L : OWN_P;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!l_req || issue_l) begin
      consec_d = '0;
    end else if (issue_p && (consec_q != CW'(MAX_CONSEC))) begin
      consec_d = consec_q + CW'(1);
    end

    if (ret_p) p_rdata_d = mem_rdata;
    if (ret_l) l_rdata_d = mem_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= '0;
      owner_q   <= OWN_P;
      consec_q  <= '0;
      rst_q     <= 1'b1;
      p_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      owner_q   <= owner_d;
      consec_q  <= consec_d;
      rst_q     <= 1'b0;
      p_rdata_q <= p_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  // Memory strobes come straight from the winning requester in the decision cycle.
  always_comb begin
    mem_en    = issue_p | issue_l;
    mem_we    = issue_p ? p_wr : (issue_l & l_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue_p) begin
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end else if (issue_l) begin
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end
    l_gnt    = issue_l;
    p_rvalid = ret_p;
    l_rvalid = ret_l;
    p_rdata  = rst_win ? '0 : (ret_p ? mem_rdata : p_rdata_q);
    l_rdata  = rst_win ? '0 : (ret_l ? mem_rdata : l_rdata_q);
    p_stall  = !rst_win && !ret_p &&
               ((p_req && !issue_p) || p_read_issue ||
                ((state_q == S_RD_WAIT) && (owner_q == OWN_P)));
  end

`ifdef SIMD_MEM_ARB_STATS_EN
  logic [15:0] stat_p_q, stat_p_d;
  logic [15:0] stat_l_q, stat_l_d;
  logic [15:0] stat_s_q, stat_s_d;

  // Saturating event counters.
  always_comb begin
    stat_p_d = stat_p_q;
    stat_l_d = stat_l_q;
    stat_s_d = stat_s_q;
    if (issue_p && (stat_p_q != 16'hFFFF)) stat_p_d = stat_p_q + 16'd1;
    if (issue_l && (stat_l_q != 16'hFFFF)) stat_l_d = stat_l_q + 16'd1;
    if (p_stall && (stat_s_q != 16'hFFFF)) stat_s_d = stat_s_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_p_q <= '0;
      stat_l_q <= '0;
      stat_s_q <= '0;
    end else begin
      stat_p_q <= stat_p_d;
      stat_l_q <= stat_l_d;
      stat_s_q <= stat_s_d;
    end
  end

  assign stat_p_grants     = stat_p_q;
  assign stat_l_grants     = stat_l_q;
  assign stat_stall_cycles = stat_s_q;
`endif

endmodule

// File: tb/tb_simd_mem_arbiter.sv
// Bench for simd_mem_arbiter: three instances (READ_LAT 1, 2, 3) share one stimulus stream and are
// checked every cycle against a timestamp-based behavioural model plus hand-computed literals.
module tb_simd_mem_arbiter;
  localparam int NI   = 3;
  localparam int MAXC = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, p_rd, p_wr, l_req, l_we;
  logic [15:0] p_addr, p_wdata, l_addr, l_wdata;
  logic [15:0] mem_rdata [NI];

  logic [15:0] p_rdata_w [NI];
  logic [15:0] l_rdata_w [NI];
  logic [15:0] mem_addr_w [NI];
  logic [15:0] mem_wdata_w [NI];
  logic        p_rvalid_w [NI];
  logic        p_stall_w [NI];
  logic        l_gnt_w [NI];
  logic        l_rvalid_w [NI];
  logic        mem_en_w [NI];
  logic        mem_we_w [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    simd_mem_arbiter #(.READ_LAT(g + 1), .MAX_CONSEC(MAXC), .AW(16), .DW(16)) u_dut (
      .clock(clock), .reset(reset),
      .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_rdata(p_rdata_w[g]), .p_rvalid(p_rvalid_w[g]), .p_stall(p_stall_w[g]),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt_w[g]), .l_rdata(l_rdata_w[g]), .l_rvalid(l_rvalid_w[g]),
      .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]), .mem_addr(mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]), .mem_rdata(mem_rdata[g])
    );
  end

  // Model: a pending read is a (return cycle, owner, data) record; the port is free when none is
  // pending or on its return cycle.
  int          cyc;
  bit          prev_rst;
  bit          pv [NI];
  int          rc [NI];
  bit          who_l [NI];
  logic [15:0] rd [NI];
  logic [15:0] hp [NI];
  logic [15:0] hl [NI];
  int          cons [NI];
  logic [15:0] mem_m [NI][256];
  bit          e_ip [NI];
  bit          e_il [NI];
  bit          e_ret [NI];
  bit          e_win;

  int n_run;
  int n_fail;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @cyc %0d: got %h, want %h", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic step();
    bit ret, can, preq, lblk, ip, il, epv, elv, een, ewe, est;
    logic [15:0] epr, elr;
    for (int i = 0; i < NI; i++)
      mem_rdata[i] = (pv[i] && rc[i] == cyc) ? rd[i] : (16'hDEAD ^ 16'(cyc));
    @(negedge clock);
    e_win = reset || prev_rst;
    for (int i = 0; i < NI; i++) begin
      ret  = !e_win && pv[i] && (rc[i] == cyc);
      can  = !e_win && (!pv[i] || ret);
      preq = p_rd || p_wr;
      lblk = l_req && (cons[i] == MAXC);
      ip   = can && preq && !lblk;
      il   = can && !(preq && !lblk) && l_req;
      e_ip[i] = ip; e_il[i] = il; e_ret[i] = ret;
      epv = ret && !who_l[i];
      elv = ret && who_l[i];
      epr = e_win ? 16'h0 : (epv ? rd[i] : hp[i]);
      elr = e_win ? 16'h0 : (elv ? rd[i] : hl[i]);
      een = ip || il;
      ewe = ip ? p_wr : (il && l_we);
      est = !e_win && !epv && ((preq && !ip) || (ip && !p_wr) || (pv[i] && !who_l[i] && !ret));
      chk("mem_en", i, 32'(mem_en_w[i]), 32'(een));
      chk("mem_we", i, 32'(mem_we_w[i]), 32'(ewe));
      chk("l_gnt", i, 32'(l_gnt_w[i]), 32'(il));
      chk("p_rvalid", i, 32'(p_rvalid_w[i]), 32'(epv));
      chk("l_rvalid", i, 32'(l_rvalid_w[i]), 32'(elv));
      chk("p_rdata", i, 32'(p_rdata_w[i]), 32'(epr));
      chk("l_rdata", i, 32'(l_rdata_w[i]), 32'(elr));
      chk("p_stall", i, 32'(p_stall_w[i]), 32'(est));
      if (een) begin
        chk("mem_addr", i, 32'(mem_addr_w[i]), 32'(ip ? p_addr : l_addr));
        chk("mem_wdata", i, 32'(mem_wdata_w[i]), 32'(ip ? p_wdata : l_wdata));
      end else if (e_win) begin
        chk("mem_addr_rst", i, 32'(mem_addr_w[i]), 32'h0);
        chk("mem_wdata_rst", i, 32'(mem_wdata_w[i]), 32'h0);
      end
    end
  endtask

  task automatic adv();
    @(posedge clock);
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        pv[i] = 1'b0; cons[i] = 0; hp[i] = 16'h0; hl[i] = 16'h0;
      end else if (!e_win) begin
        if (e_ret[i]) begin
          if (who_l[i]) hl[i] = rd[i]; else hp[i] = rd[i];
          pv[i] = 1'b0;
        end
        if (e_ip[i]) begin
          if (p_wr) mem_m[i][p_addr[7:0]] = p_wdata;
          else begin
            pv[i] = 1'b1; rc[i] = cyc + i + 1; who_l[i] = 1'b0; rd[i] = mem_m[i][p_addr[7:0]];
          end
        end
        if (e_il[i]) begin
          if (l_we) mem_m[i][l_addr[7:0]] = l_wdata;
          else begin
            pv[i] = 1'b1; rc[i] = cyc + i + 1; who_l[i] = 1'b1; rd[i] = mem_m[i][l_addr[7:0]];
          end
        end
        if (!l_req || e_il[i]) cons[i] = 0;
        else if (e_ip[i] && cons[i] < MAXC) cons[i] = cons[i] + 1;
      end
    end
    prev_rst = reset;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    p_rd = 1'b0; p_wr = 1'b0; l_req = 1'b0; l_we = 1'b0;
    repeat (n) begin step(); adv(); end
  endtask

  initial begin
    n_run = 0; n_fail = 0; cyc = 0; prev_rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      pv[i] = 1'b0; rc[i] = 0; who_l[i] = 1'b0; rd[i] = 16'h0;
      hp[i] = 16'h0; hl[i] = 16'h0; cons[i] = 0; mem_rdata[i] = 16'h0;
      for (int k = 0; k < 256; k++) mem_m[i][k] = 16'hA500 | 16'(k);
      mem_m[i][8'h20] = 16'h1234;
      mem_m[i][8'hFF] = 16'hC0DE;
    end
    reset = 1'b1; p_rd = 1'b0; p_wr = 1'b1; l_req = 1'b1; l_we = 1'b1;
    p_addr = 16'h0; p_wdata = 16'h0; l_addr = 16'h0; l_wdata = 16'h0;

    // Reset held with requests active, then the quiet cycle after release.
    repeat (2) begin
      step();
      chk("rst_mem_en", 0, 32'(mem_en_w[0]), 32'h0);
      chk("rst_l_gnt", 1, 32'(l_gnt_w[1]), 32'h0);
      adv();
    end
    reset = 1'b0;
    step();
    chk("post_rst_mem_en", 0, 32'(mem_en_w[0]), 32'h0);
    chk("post_rst_stall", 2, 32'(p_stall_w[2]), 32'h0);
    adv();
    idle(2);

    // P write only.
    p_wr = 1'b1; p_addr = 16'h0010; p_wdata = 16'hBEEF;
    step();
    chk("pw_en", 0, 32'(mem_en_w[0]), 32'h1);
    chk("pw_we", 0, 32'(mem_we_w[0]), 32'h1);
    chk("pw_addr", 0, 32'(mem_addr_w[0]), 32'h0010);
    chk("pw_wdata", 0, 32'(mem_wdata_w[0]), 32'hBEEF);
    chk("pw_stall", 0, 32'(p_stall_w[0]), 32'h0);
    adv();
    idle(3);

    // P read with READ_LAT=2 (instance 1).
    p_rd = 1'b1; p_addr = 16'h0020;
    step();
    chk("pr2_en_t", 1, 32'(mem_en_w[1]), 32'h1);
    chk("pr2_stall_t", 1, 32'(p_stall_w[1]), 32'h1);
    adv();
    step();
    chk("pr2_stall_t1", 1, 32'(p_stall_w[1]), 32'h1);
    chk("pr2_en_t1", 1, 32'(mem_en_w[1]), 32'h0);
    adv();
    step();
    chk("pr2_rvalid_t2", 1, 32'(p_rvalid_w[1]), 32'h1);
    chk("pr2_rdata_t2", 1, 32'(p_rdata_w[1]), 32'h1234);
    chk("pr2_stall_t2", 1, 32'(p_stall_w[1]), 32'h0);
    adv();
    idle(6);

    // Contention: P keeps writing while L waits; L must get in after MAX_CONSEC P grants.
    p_wr = 1'b1; p_addr = 16'h0030; p_wdata = 16'h1111;
    l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0040; l_wdata = 16'h2222;
    for (int k = 0; k < MAXC; k++) begin
      step();
      chk("ct_l_gnt_lo", 0, 32'(l_gnt_w[0]), 32'h0);
      chk("ct_stall_lo", 0, 32'(p_stall_w[0]), 32'h0);
      chk("ct_addr_p", 0, 32'(mem_addr_w[0]), 32'h0030);
      adv();
    end
    step();
    chk("ct_l_gnt_hi", 0, 32'(l_gnt_w[0]), 32'h1);
    chk("ct_stall_hi", 0, 32'(p_stall_w[0]), 32'h1);
    chk("ct_addr_l", 0, 32'(mem_addr_w[0]), 32'h0040);
    chk("ct_we_l", 0, 32'(mem_we_w[0]), 32'h1);
    adv();
    l_addr = 16'h0041;
    step();
    chk("ct_consec_clr", 0, 32'(l_gnt_w[0]), 32'h0);
    chk("ct_addr_p2", 0, 32'(mem_addr_w[0]), 32'h0030);
    adv();
    idle(3);

    // L read with READ_LAT=1 (instance 0), then a P read issued on the L return cycle.
    l_req = 1'b1; l_we = 1'b0; l_addr = 16'h00FF;
    step();
    chk("lr_gnt", 0, 32'(l_gnt_w[0]), 32'h1);
    chk("lr_we", 0, 32'(mem_we_w[0]), 32'h0);
    chk("lr_addr", 0, 32'(mem_addr_w[0]), 32'h00FF);
    adv();
    l_req = 1'b0; p_rd = 1'b1; p_addr = 16'h0020;
    step();
    chk("lr_rvalid", 0, 32'(l_rvalid_w[0]), 32'h1);
    chk("lr_rdata", 0, 32'(l_rdata_w[0]), 32'hC0DE);
    chk("lr_p_issue", 0, 32'(mem_en_w[0]), 32'h1);
    chk("lr_p_addr", 0, 32'(mem_addr_w[0]), 32'h0020);
    chk("lr_p_stall", 0, 32'(p_stall_w[0]), 32'h1);
    adv();
    p_rd = 1'b0;
    step();
    chk("lr_p_rvalid", 0, 32'(p_rvalid_w[0]), 32'h1);
    chk("lr_p_rdata", 0, 32'(p_rdata_w[0]), 32'h1234);
    chk("lr_l_hold", 0, 32'(l_rdata_w[0]), 32'hC0DE);
    chk("lr_l_rvalid_lo", 0, 32'(l_rvalid_w[0]), 32'h0);
    adv();
    idle(4);

    // Back-to-back P reads with READ_LAT=1.
    p_rd = 1'b1; p_addr = 16'h0020;
    step();
    chk("bb_stall0", 0, 32'(p_stall_w[0]), 32'h1);
    adv();
    p_addr = 16'h0021;
    step();
    chk("bb_rvalid1", 0, 32'(p_rvalid_w[0]), 32'h1);
    chk("bb_rdata1", 0, 32'(p_rdata_w[0]), 32'h1234);
    chk("bb_stall1", 0, 32'(p_stall_w[0]), 32'h0);
    chk("bb_addr1", 0, 32'(mem_addr_w[0]), 32'h0021);
    adv();
    p_addr = 16'h0022;
    step();
    chk("bb_rvalid2", 0, 32'(p_rvalid_w[0]), 32'h1);
    chk("bb_rdata2", 0, 32'(p_rdata_w[0]), 32'hA521);
    chk("bb_stall2", 0, 32'(p_stall_w[0]), 32'h0);
    adv();
    idle(5);

    // Reset during an outstanding READ_LAT=3 read (instance 2): the read must vanish.
    p_rd = 1'b1; p_addr = 16'h0020;
    step();
    chk("rr_issue", 2, 32'(mem_en_w[2]), 32'h1);
    adv();
    reset = 1'b1;
    step();
    chk("rr_rst_stall", 2, 32'(p_stall_w[2]), 32'h0);
    chk("rr_rst_en", 2, 32'(mem_en_w[2]), 32'h0);
    adv();
    reset = 1'b0;
    step();
    chk("rr_post_en", 2, 32'(mem_en_w[2]), 32'h0);
    chk("rr_post_stall", 2, 32'(p_stall_w[2]), 32'h0);
    chk("rr_post_rvalid", 2, 32'(p_rvalid_w[2]), 32'h0);
    adv();
    p_rd = 1'b0;
    repeat (2) begin
      step();
      chk("rr_no_rvalid", 2, 32'(p_rvalid_w[2]), 32'h0);
      adv();
    end
    idle(3);

    // Read and write together behave as a single write.
    p_rd = 1'b1; p_wr = 1'b1; p_addr = 16'h0050; p_wdata = 16'h5555;
    step();
    chk("rw_en", 1, 32'(mem_en_w[1]), 32'h1);
    chk("rw_we", 1, 32'(mem_we_w[1]), 32'h1);
    chk("rw_wdata", 1, 32'(mem_wdata_w[1]), 32'h5555);
    chk("rw_stall", 1, 32'(p_stall_w[1]), 32'h0);
    adv();
    p_rd = 1'b0; p_wr = 1'b0;
    repeat (3) begin
      step();
      chk("rw_no_rvalid", 1, 32'(p_rvalid_w[1]), 32'h0);
      adv();
    end

    // Mixed traffic, checked by the model only.
    for (int k = 0; k < 80; k++) begin
      p_rd    = 1'($urandom_range(0, 1));
      p_wr    = ($urandom_range(0, 3) == 0);
      p_addr  = 16'($urandom_range(0, 15));
      p_wdata = 16'($urandom);
      l_req   = 1'($urandom_range(0, 1));
      l_we    = 1'($urandom_range(0, 1));
      l_addr  = 16'($urandom_range(0, 15));
      l_wdata = 16'($urandom);
      reset   = ($urandom_range(0, 39) == 0);
      step();
      adv();
    end
    reset = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
